// File: rtl/pipe_reg_pkg.sv
// Shared constants for the pipeline register family.
// Holds the standard field widths used at pipeline-stage boundaries and the
// default reset value. The default reset value is kept at the widest legal
// width and is sliced down by each user.
package pipe_reg_pkg;

    // Destination register address width (register file index).
    localparam int REG_ADDR_W = 5;

    // Datapath width (memory read data, ALU result).
    localparam int DATA_W = 32;

    // Widest data width a pipeline register may be built with.
    localparam int MAX_W = 64;

    // Value loaded on reset unless an instance overrides it.
    localparam logic [MAX_W-1:0] DEFAULT_RESET_VALUE = 64'h0;

endpackage : pipe_reg_pkg

// File: rtl/pipe_reg.sv
// Generic edge-triggered pipeline register plus fixed-width wrappers.
//
// pipe_reg (parameterised core)
//   WIDTH        data width in bits, 1..64
//   RESET_VALUE  value loaded while clrn is low at a rising edge
//   clk   in   1      rising-edge clock
//   clrn  in   1      synchronous active-low clear (outranks en)
//   en    in   1      load enable, 1 = capture d
//   d     in   WIDTH  next-stage data
//   q     out  WIDTH  registered data, one cycle after d
//
// dff1 / dff5 / dff32 (wrappers kept for existing positional call sites)
//   Port order d, clk, clrn, q; widths 1, 5 and 32; enable tied high and
//   reset value zero. Each one delays d by exactly one clock.
//
// q is driven only by the flop: there is no combinational path from d, en
// or clrn to q, and clrn has no effect between edges.
module pipe_reg
    import pipe_reg_pkg::*;
#(
    parameter int               WIDTH       = DATA_W,
    parameter logic [WIDTH-1:0] RESET_VALUE = DEFAULT_RESET_VALUE[WIDTH-1:0]
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Stage register: clear beats load, load beats hold.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            q <= RESET_VALUE;
        end else if (en) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule : pipe_reg

// 1-bit pipeline flop, e.g. wreg / m2reg control bits.
module dff1
    import pipe_reg_pkg::*;
(
    input  logic d,
    input  logic clk,
    input  logic clrn,
    output logic q
);

    pipe_reg #(
        .WIDTH       (1),
        .RESET_VALUE (1'b0)
    ) u_reg (
        .clk  (clk),
        .clrn (clrn),
        .en   (1'b1),
        .d    (d),
        .q    (q)
    );

endmodule : dff1

// 5-bit pipeline register, e.g. destination register number.
module dff5
    import pipe_reg_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] d,
    input  logic                  clk,
    input  logic                  clrn,
    output logic [REG_ADDR_W-1:0] q
);

    pipe_reg #(
        .WIDTH       (REG_ADDR_W),
        .RESET_VALUE (DEFAULT_RESET_VALUE[REG_ADDR_W-1:0])
    ) u_reg (
        .clk  (clk),
        .clrn (clrn),
        .en   (1'b1),
        .d    (d),
        .q    (q)
    );

endmodule : dff5

// 32-bit pipeline register, e.g. memory read data or ALU result.
module dff32
    import pipe_reg_pkg::*;
(
    input  logic [DATA_W-1:0] d,
    input  logic              clk,
    input  logic              clrn,
    output logic [DATA_W-1:0] q
);

    pipe_reg #(
        .WIDTH       (DATA_W),
        .RESET_VALUE (DEFAULT_RESET_VALUE[DATA_W-1:0])
    ) u_reg (
        .clk  (clk),
        .clrn (clrn),
        .en   (1'b1),
        .d    (d),
        .q    (q)
    );

endmodule : dff32

// File: tb/tb_pipe_reg.sv
// Directed, scoreboard-based bench for pipe_reg and its wrappers.
// Expected values are queued when stimulus is driven and compared once the
// corresponding clock edge (or the mid-cycle observation point) is reached.
module tb_pipe_reg;

    localparam int ID_DFF1   = 0;
    localparam int ID_DFF5   = 1;
    localparam int ID_DFF32  = 2;
    localparam int ID_CORE32 = 3;
    localparam int ID_CORE8  = 4;

    typedef struct {
        int          id;
        logic [63:0] exp;
        string       tag;
    } sb_entry_t;

    logic        clk;
    logic        clrn;
    logic        d1;
    logic [4:0]  d5;
    logic [31:0] d32;
    logic        q1;
    logic [4:0]  q5;
    logic [31:0] q32;

    logic        en32;
    logic [31:0] dc32;
    logic [31:0] qc32;

    logic        clrn8;
    logic        en8;
    logic [7:0]  d8;
    logic [7:0]  q8;

    sb_entry_t   sb[$];
    int          checks;
    int          passed;

    dff1  u_dff1  (.d(d1),  .clk(clk), .clrn(clrn), .q(q1));
    dff5  u_dff5  (.d(d5),  .clk(clk), .clrn(clrn), .q(q5));
    dff32 u_dff32 (.d(d32), .clk(clk), .clrn(clrn), .q(q32));

    pipe_reg #(
        .WIDTH (32)
    ) u_core32 (
        .clk  (clk),
        .clrn (clrn),
        .en   (en32),
        .d    (dc32),
        .q    (qc32)
    );

    pipe_reg #(
        .WIDTH       (8),
        .RESET_VALUE (8'h3C)
    ) u_core8 (
        .clk  (clk),
        .clrn (clrn8),
        .en   (en8),
        .d    (d8),
        .q    (q8)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] observe(input int id);
        case (id)
            ID_DFF1:   return {63'h0, q1};
            ID_DFF5:   return {59'h0, q5};
            ID_DFF32:  return {32'h0, q32};
            ID_CORE32: return {32'h0, qc32};
            ID_CORE8:  return {56'h0, q8};
            default:   return {64{1'bx}};
        endcase
    endfunction

    task automatic sb_push(input int id, input logic [63:0] exp, input string tag);
        sb_entry_t e;
        e.id  = id;
        e.exp = exp;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Queue the expected values of all three wrappers from one 32-bit value.
    task automatic expect_wrappers(input logic [31:0] v, input string tag);
        logic [31:0] t;
        t = v;
        sb_push(ID_DFF32, {32'h0, t}, {tag, "/dff32"});
        sb_push(ID_DFF5,  {59'h0, t[4:0]}, {tag, "/dff5"});
        sb_push(ID_DFF1,  {63'h0, t[0]}, {tag, "/dff1"});
    endtask

    // Drive the same 32-bit pattern to all wrappers and the 32-bit core.
    task automatic drive_all(input logic [31:0] v);
        logic [31:0] t;
        t    = v;
        d32  = t;
        d5   = t[4:0];
        d1   = t[0];
        dc32 = t;
    endtask

    task automatic drain();
        sb_entry_t   e;
        logic [63:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.id);
            checks++;
            assert (obs === e.exp) passed++;
            else $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drain();
    endtask

    initial begin
        checks = 0;
        passed = 0;
        clk    = 1'b0;
        clrn   = 1'b0;
        en32   = 1'b1;
        drive_all(32'hDEADBEEF);
        clrn8  = 1'b0;
        en8    = 1'b1;
        d8     = 8'hFF;

        // 1. Reset held for two edges with non-zero data.
        for (int i = 0; i < 2; i++) begin
            expect_wrappers(32'h0, "reset");
            sb_push(ID_CORE32, 64'h0, "reset/core32");
            sb_push(ID_CORE8, 64'h3C, "reset/core8");
            step();
        end

        // 2. First capture; q must not move before the edge.
        clrn = 1'b1;
        drive_all(32'h00000005);
        d5   = 5'h1F;
        d1   = 1'b1;
        #2;
        expect_wrappers(32'h0, "pre_edge");
        drain();
        sb_push(ID_DFF32, 64'h5, "capture/dff32");
        sb_push(ID_DFF5, 64'h1F, "capture/dff5");
        sb_push(ID_DFF1, 64'h1, "capture/dff1");
        sb_push(ID_CORE32, 64'h5, "capture/core32");
        step();

        // 3. Back-to-back stream, one cycle of latency each.
        for (int i = 1; i <= 4; i++) begin
            drive_all(32'(i));
            expect_wrappers(32'(i), "stream");
            sb_push(ID_CORE32, 64'(i), "stream/core32");
            step();
        end

        // 4a. clrn pulsed low strictly between edges: no effect.
        #2;
        clrn = 1'b0;
        #1;
        expect_wrappers(32'h4, "mid_pulse");
        drain();
        #1;
        clrn = 1'b1;
        expect_wrappers(32'h4, "pulse_hold");
        sb_push(ID_CORE32, 64'h4, "pulse_hold/core32");
        step();

        // 4b. clrn low across an edge clears all-ones data.
        clrn = 1'b0;
        drive_all(32'hFFFFFFFF);
        expect_wrappers(32'h0, "sync_clear");
        sb_push(ID_CORE32, 64'h0, "sync_clear/core32");
        step();

        // X propagation and reset clearing X.
        clrn = 1'b1;
        d5   = 5'bxxxxx;
        sb_push(ID_DFF5, {59'h0, 5'bxxxxx}, "x_prop/dff5");
        step();
        clrn = 1'b0;
        sb_push(ID_DFF5, 64'h0, "x_clear/dff5");
        step();
        clrn = 1'b1;

        // 5. Enable on the core: load, hold, reset beats disabled, reload.
        en32 = 1'b1;
        dc32 = 32'h12345678;
        sb_push(ID_CORE32, 64'h12345678, "en_load/core32");
        step();
        en32 = 1'b0;
        dc32 = 32'hA5A5A5A5;
        sb_push(ID_CORE32, 64'h12345678, "en_hold/core32");
        step();
        clrn = 1'b0;
        sb_push(ID_CORE32, 64'h0, "en_off_reset/core32");
        step();
        clrn = 1'b1;
        en32 = 1'b1;
        sb_push(ID_CORE32, 64'hA5A5A5A5, "en_reload/core32");
        step();

        // 6. Non-default width and reset value, full-width toggling.
        clrn8 = 1'b0;
        d8    = 8'hFF;
        sb_push(ID_CORE8, 64'h3C, "w8_reset");
        step();
        clrn8 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d8 = (i % 2 == 0) ? 8'hFF : 8'h00;
            sb_push(ID_CORE8, (i % 2 == 0) ? 64'hFF : 64'h00, "w8_toggle");
            step();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_pipe_reg
